// File: rtl/datapath_unit.sv
// Processor datapath: 16-entry register file with registered read ports,
// synchronous data RAM, 16-bit ALU and the write-back mux.
module datapath_unit #(
  parameter int DATA_W   = 16,
  parameter int RF_DEPTH = 16,
  parameter int DM_DEPTH = 256,
  localparam int RF_AW   = $clog2(RF_DEPTH),
  localparam int DM_AW   = $clog2(DM_DEPTH)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [DM_AW-1:0]  d_addr,
  input  logic              d_wr,
  input  logic              rf_s,
  input  logic [RF_AW-1:0]  rf_w_addr,
  input  logic              rf_w_wr,
  input  logic [RF_AW-1:0]  rf_ra_addr,
  input  logic              rf_ra_rd,
  input  logic [RF_AW-1:0]  rf_rb_addr,
  input  logic              rf_rb_rd,
  input  logic [2:0]        alu_s0,
  output logic [DATA_W-1:0] ra_data,
  output logic [DATA_W-1:0] rb_data,
  output logic [DATA_W-1:0] alu_out,
  output logic              alu_zero,
  output logic [DATA_W-1:0] w_data
);

  logic [DATA_W-1:0] rf_r [RF_DEPTH];
  logic [DATA_W-1:0] mem_r [DM_DEPTH];
  logic [DATA_W-1:0] dm_q_r;

  // Register file and read ports; reads see pre-edge contents, so no bypass.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < RF_DEPTH; i++) begin
        rf_r[i] <= {DATA_W{1'b0}};
      end
      ra_data <= {DATA_W{1'b0}};
      rb_data <= {DATA_W{1'b0}};
    end else begin
      if (rf_w_wr) begin
        rf_r[rf_w_addr] <= w_data;
      end
      if (rf_ra_rd) begin
        ra_data <= rf_r[rf_ra_addr];
      end
      if (rf_rb_rd) begin
        rb_data <= rf_r[rf_rb_addr];
      end
    end
  end

  // RAM array: contents survive reset; STORE writes the pre-edge port A data.
  always_ff @(posedge clock) begin
    if (d_wr) begin
      mem_r[d_addr] <= ra_data;
    end
  end

  // RAM read register, cleared by reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      dm_q_r <= {DATA_W{1'b0}};
    end else begin
      dm_q_r <= mem_r[d_addr];
    end
  end

  // ALU, modulo 2^DATA_W.
  always_comb begin
    alu_out = {DATA_W{1'b0}};
    case (alu_s0)
      3'b000:  alu_out = {DATA_W{1'b0}};
      3'b001:  alu_out = ra_data + rb_data;
      3'b010:  alu_out = ra_data - rb_data;
      3'b011:  alu_out = ra_data;
      3'b100:  alu_out = ra_data ^ rb_data;
      3'b101:  alu_out = ra_data | rb_data;
      3'b110:  alu_out = ra_data & rb_data;
      3'b111:  alu_out = ra_data + DATA_W'(1);
      default: alu_out = {DATA_W{1'b0}};
    endcase
  end

  // Zero flag and write-back select.
  always_comb begin
    alu_zero = (alu_out == {DATA_W{1'b0}});
    if (rf_s) begin
      w_data = dm_q_r;
    end else begin
      w_data = alu_out;
    end
  end

endmodule

// File: tb/tb_datapath_unit.sv
// Self-checking bench for datapath_unit: directed sequences plus a table-driven ALU sweep.
module tb_datapath_unit;

  logic        clock;
  logic        reset;
  logic [7:0]  d_addr;
  logic        d_wr;
  logic        rf_s;
  logic [3:0]  rf_w_addr;
  logic        rf_w_wr;
  logic [3:0]  rf_ra_addr;
  logic        rf_ra_rd;
  logic [3:0]  rf_rb_addr;
  logic        rf_rb_rd;
  logic [2:0]  alu_s0;
  logic [15:0] ra_data;
  logic [15:0] rb_data;
  logic [15:0] alu_out;
  logic        alu_zero;
  logic [15:0] w_data;

  int n_checks;
  int n_fail;

  typedef struct {
    logic [2:0]  fn;
    logic [15:0] exp_out;
    logic        exp_zero;
  } alu_vec_t;

  alu_vec_t vecs [8];

  datapath_unit dut (
    .clock      (clock),
    .reset      (reset),
    .d_addr     (d_addr),
    .d_wr       (d_wr),
    .rf_s       (rf_s),
    .rf_w_addr  (rf_w_addr),
    .rf_w_wr    (rf_w_wr),
    .rf_ra_addr (rf_ra_addr),
    .rf_ra_rd   (rf_ra_rd),
    .rf_rb_addr (rf_rb_addr),
    .rf_rb_rd   (rf_rb_rd),
    .alu_s0     (alu_s0),
    .ra_data    (ra_data),
    .rb_data    (rb_data),
    .alu_out    (alu_out),
    .alu_zero   (alu_zero),
    .w_data     (w_data)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    d_wr = 1'b0; rf_s = 1'b0; rf_w_wr = 1'b0;
    rf_ra_rd = 1'b0; rf_rb_rd = 1'b0; alu_s0 = 3'b000;
  endtask

  // read edge, then write-back edge through the ALU
  task automatic op(input logic [3:0] wa, input logic [3:0] aa, input logic [3:0] ba, input logic [2:0] fn);
    rf_ra_rd = 1'b1; rf_ra_addr = aa; rf_rb_rd = 1'b1; rf_rb_addr = ba;
    cyc();
    rf_ra_rd = 1'b0; rf_rb_rd = 1'b0;
    alu_s0 = fn; rf_s = 1'b0; rf_w_wr = 1'b1; rf_w_addr = wa;
    cyc();
    idle();
  endtask

  // builds a constant by shift-and-add using only ALU operations (R0 stays 0)
  task automatic load_const(input logic [3:0] r, input logic [15:0] val);
    op(r, 4'd0, 4'd0, 3'b000);
    for (int i = 15; i >= 0; i--) begin
      op(r, r, r, 3'b001);
      if (val[i]) op(r, r, 4'd0, 3'b111);
    end
  endtask

  task automatic read_ab(input logic [3:0] a, input logic [3:0] b);
    rf_ra_rd = 1'b1; rf_ra_addr = a; rf_rb_rd = 1'b1; rf_rb_addr = b;
    cyc();
    rf_ra_rd = 1'b0; rf_rb_rd = 1'b0;
  endtask

  task automatic store(input logic [3:0] r, input logic [7:0] a);
    rf_ra_rd = 1'b1; rf_ra_addr = r;
    cyc();
    rf_ra_rd = 1'b0; d_wr = 1'b1; d_addr = a;
    cyc();
    d_wr = 1'b0;
  endtask

  task automatic check_ram(input string name, input logic [7:0] a, input logic [15:0] exp);
    d_addr = a;
    cyc();
    rf_s = 1'b1;
    #1;
    check(name, w_data, exp);
    rf_s = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_fail = 0;
    vecs[0] = '{3'b000, 16'h0000, 1'b1};
    vecs[1] = '{3'b001, 16'h0FFF, 1'b0};
    vecs[2] = '{3'b010, 16'hF1E1, 1'b0};
    vecs[3] = '{3'b011, 16'h00F0, 1'b0};
    vecs[4] = '{3'b100, 16'h0FFF, 1'b0};
    vecs[5] = '{3'b101, 16'h0FFF, 1'b0};
    vecs[6] = '{3'b110, 16'h0000, 1'b1};
    vecs[7] = '{3'b111, 16'h00F1, 1'b0};

    d_addr = 8'h00; rf_w_addr = 4'd0; rf_ra_addr = 4'd0; rf_rb_addr = 4'd0;
    idle();
    reset = 1'b1;
    cyc();
    cyc();
    alu_s0 = 3'b111; rf_s = 1'b0;
    #1;
    check("reset_alu_inc", alu_out, 16'h0001);
    check("reset_zero_inc", {15'd0, alu_zero}, 16'h0000);
    rf_s = 1'b1; alu_s0 = 3'b001;
    #1;
    check("reset_wdata_ram", w_data, 16'h0000);
    check("reset_zero_add", {15'd0, alu_zero}, 16'h0001);
    idle();
    #2;
    reset = 1'b0;
    cyc();

    // 1: asynchronous reset mid-cycle with a pending write
    op(4'd2, 4'd0, 4'd0, 3'b111);
    read_ab(4'd2, 4'd2);
    check("pre_reset_ra", ra_data, 16'h0001);
    rf_w_wr = 1'b1; rf_w_addr = 4'd5; alu_s0 = 3'b111;
    #2;
    reset = 1'b1;
    #1;
    check("async_reset_ra", ra_data, 16'h0000);
    check("async_reset_rb", rb_data, 16'h0000);
    cyc();
    #2;
    idle();
    reset = 1'b0;
    cyc();
    for (int i = 0; i < 8; i++) begin
      read_ab(4'(i), 4'(i + 8));
      check($sformatf("reset_r%0d", i), ra_data, 16'h0000);
      check($sformatf("reset_r%0d", i + 8), rb_data, 16'h0000);
    end

    // 4 (prep): mem[00] = 0 from R0
    store(4'd0, 8'h00);

    // 2: LOAD R3 from mem[1B]
    load_const(4'd12, 16'h1234);
    store(4'd12, 8'h1B);
    d_addr = 8'h1B;
    cyc();
    rf_s = 1'b1; rf_w_wr = 1'b1; rf_w_addr = 4'd3;
    cyc();
    idle();
    read_ab(4'd3, 4'd0);
    check("load_r3", ra_data, 16'h1234);

    // 3: ADD / SUB with wrap
    load_const(4'd1, 16'hFFFF);
    load_const(4'd2, 16'h0002);
    read_ab(4'd1, 4'd2);
    alu_s0 = 3'b001; rf_w_wr = 1'b1; rf_w_addr = 4'd4;
    #1;
    check("add_out", alu_out, 16'h0001);
    check("add_zero", {15'd0, alu_zero}, 16'h0000);
    cyc();
    idle();
    read_ab(4'd2, 4'd1);
    alu_s0 = 3'b010; rf_w_wr = 1'b1; rf_w_addr = 4'd5;
    #1;
    check("sub_out", alu_out, 16'h0003);
    check("sub_zero", {15'd0, alu_zero}, 16'h0000);
    cyc();
    idle();
    read_ab(4'd4, 4'd5);
    check("r4", ra_data, 16'h0001);
    check("r5", rb_data, 16'h0003);

    // 4: STORE to top address, low address untouched
    load_const(4'd6, 16'h00AA);
    store(4'd6, 8'hFF);
    check_ram("ram_ff", 8'hFF, 16'h00AA);
    check_ram("ram_00", 8'h00, 16'h0000);

    // 5: write and read R7 on the same edge returns old data
    load_const(4'd7, 16'h1111);
    load_const(4'd10, 16'h5555);
    read_ab(4'd10, 4'd0);
    alu_s0 = 3'b001; rf_w_wr = 1'b1; rf_w_addr = 4'd7;
    rf_ra_rd = 1'b1; rf_ra_addr = 4'd7;
    cyc();
    idle();
    check("rdw_old", ra_data, 16'h1111);
    read_ab(4'd7, 4'd0);
    check("rdw_new", ra_data, 16'h5555);

    // 6: ALU sweep
    load_const(4'd8, 16'h00F0);
    load_const(4'd9, 16'h0F0F);
    read_ab(4'd8, 4'd9);
    for (int i = 0; i < 8; i++) begin
      alu_s0 = vecs[i].fn;
      #1;
      check($sformatf("alu_%0d_out", i), alu_out, vecs[i].exp_out);
      check($sformatf("alu_%0d_zero", i), {15'd0, alu_zero}, {15'd0, vecs[i].exp_zero});
    end
    idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/datapath_unit.md
# datapath_unit

Processor datapath driven by `control_unit`. It holds:
- a 16×16 register file with two registered read ports and one write port;
- a 256×16 data RAM;
- a 16-bit ALU;
- the write-back mux selected by `rf_s`.

It sits directly downstream of `control_unit`, consumes every RF, RAM and ALU control it emits, and executes the NOOP/STORE/LOAD/ADD/SUB/HALT instruction set one control step at a time.

## Interface
Parameters:
- `DATA_W`, 16, datapath word width
- `RF_DEPTH`, 16, register count (address width 4)
- `DM_DEPTH`, 256, data RAM words (address width 8)

Ports:
- `clock` in 1: system clock; all state updates on its rising edge.
- `reset` in 1: asynchronous, active-high; one clock.
- `d_addr` in 8: data RAM address.
- `d_wr` in 1: data RAM write enable.
- `rf_s` in 1: write-back select; 0 = ALU result, 1 = RAM read data.
- `rf_w_addr` in 4: RF write address.
- `rf_w_wr` in 1: RF write enable.
- `rf_ra_addr` in 4: RF port A address.
- `rf_ra_rd` in 1: port A read enable.
- `rf_rb_addr` in 4: RF port B address.
- `rf_rb_rd` in 1: port B read enable.
- `alu_s0` in 3: ALU function select.
- `ra_data` out 16: registered port A data.
- `rb_data` out 16: registered port B data.
- `alu_out` out 16: combinational ALU result.
- `alu_zero` out 1: high when `alu_out` == 0.
- `w_data` out 16: write-back mux output, visible for debug.

## Operation
Register file:
- Write: on a rising edge with `rf_w_wr`=1, `rf[rf_w_addr] <= w_data`. All 16 registers are writable, including R0.
- Read: on a rising edge with `rf_ra_rd`=1, `ra_data <= rf[rf_ra_addr]`; port B behaves identically with its own enable and address.
- A port with its read enable at 0 holds its value.
- Read-during-write to the same address returns the OLD contents (no bypass).
- Both ports may read the same address in the same cycle.

Data RAM:
- Synchronous read every cycle: `dm_q <= mem[d_addr]`.
- Write: on a rising edge with `d_wr`=1, `mem[d_addr] <= ra_data`, i.e. STORE writes port A data.
- Read-during-write to the same address gives old data in `dm_q`.
- RAM contents are not affected by `reset`; they power up undefined in simulation.

Write-back: `w_data = rf_s ? dm_q : alu_out`.

ALU (`A` = `ra_data`, `B` = `rb_data`). All arithmetic is modulo 2^16; carry and borrow are discarded.
- 000: 0
- 001: A+B
- 010: A−B
- 011: A
- 100: A^B
- 101: A|B
- 110: A&B
- 111: A+1

## Timing
Reset:
- While `reset` is high: all 16 RF entries = 0, `ra_data` = `rb_data` = 0, `dm_q` = 0.
- Resulting outputs: `alu_out` = f(0,0), i.e. 0 for every select except 111 → 1; `alu_zero` = 1 unless `alu_s0` = 111; `w_data` = 0 when `rf_s`=1, else `alu_out`.
- Reset asserted mid-operation clears state immediately; any write on that edge is lost.

Latencies:
- RF read: 1 cycle. Address and enable at edge N → data valid after edge N.
- RAM read: 1 cycle, so LOAD needs `d_addr` presented one edge before the `rf_w_wr` edge with `rf_s`=1.
- ADD/SUB: read edge N, write-back at edge N+1 with `rf_s`=0 (ALU path is combinational).
- Same-edge events:
  - `rf_w_wr` together with `rf_ra_rd` to the same address: RF takes the new value; `ra_data` gets the old one.
  - STORE on the same edge as a port A read: the RAM takes the pre-edge `ra_data`.
- `d_addr` 8'hFF and `rf_*_addr` 4'hF are ordinary locations; there is no wrap or aliasing.
- No handshakes: every control input is sampled each edge.

## Test plan
1. Assert `reset` asynchronously mid-clock, with a write enabled on the next edge → `ra_data`/`rb_data` = 0 immediately, and no register is written while reset is high; after release, reading R0–R15 returns 0 for all.
2. Preload mem[8'h1B]=16'h1234. LOAD R3 (`d_addr`=1B, then `rf_s`=1, `rf_w_wr`=1, `rf_w_addr`=3), then read A=3 → `ra_data`=16'h1234.
3. R1=16'hFFFF, R2=16'h0002: ADD into R4 → R4=16'h0001; SUB R2−R1 into R5 → R5=16'h0003; `alu_zero`=0 for both.
4. R6=16'h00AA, STORE to `d_addr`=8'hFF, then read address 8'hFF → `dm_q`=16'h00AA; address 8'h00 is unchanged.
5. Same edge: write R7=16'h5555 (old value 16'h1111) while reading A=7 → `ra_data`=16'h1111; the next read gives 16'h5555.
6. Sweep `alu_s0` 000–111 with A=16'h00F0, B=16'h0F0F → 0000, 0FFF, F1E1, 00F0, 0FFF, 0FFF, 0000, 00F1; `alu_zero`=1 only for 000 and 110.
